// File: rtl/keypad_scan_ctrl.sv
// 4x4 hex keypad scanner: paced column drive, synchronized/debounced row
// returns, key-code encoding and a small valid/ready FIFO toward the consumer.
module keypad_scan_ctrl #(
  parameter int CLK_DIV    = 1000,
  parameter int DEBOUNCE   = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       overflow,
  output logic       busy
);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [3:0]       DEB_LAST  = 4'(DEBOUNCE);
  localparam logic [CNT_W-1:0] FIFO_FULL = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, SCAN, CONFIRM, HELD} state_t;

  state_t           state, state_nx;
  logic [3:0]       row_m, row_s;
  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic [1:0]       col_idx, col_idx_nx;
  logic [3:0]       row_r, row_r_nx;
  logic [3:0]       deb_cnt, deb_cnt_nx;
  logic [3:0]       rel_cnt, rel_cnt_nx;
  logic             push;
  logic             row_one_hot;
  logic [1:0]       row_idx;
  logic [3:0]       col_drive;

  logic [3:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             full, pop, push_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_m <= '0;
      row_s <= '0;
    end else begin
      row_m <= row;
      row_s <= row_m;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      div_cnt <= '0;
    else if (!en)                 div_cnt <= '0;
    else if (div_cnt == DIV_LAST) div_cnt <= '0;
    else                          div_cnt <= div_cnt + 1'b1;
  end

  assign tick        = en && (div_cnt == DIV_LAST);
  assign row_one_hot = (row_s != 4'd0) && ((row_s & (row_s - 4'd1)) == 4'd0);

  always_comb begin
    row_idx = 2'd0;
    for (int i = 1; i < 4; i++)
      if (row_r[i]) row_idx = 2'(i);
  end

  always_comb begin
    state_nx   = state;
    col_idx_nx = col_idx;
    row_r_nx   = row_r;
    deb_cnt_nx = deb_cnt;
    rel_cnt_nx = rel_cnt;
    push       = 1'b0;
    if (!en) begin
      state_nx   = IDLE;
      col_idx_nx = '0;
      row_r_nx   = '0;
      deb_cnt_nx = '0;
      rel_cnt_nx = '0;
    end else if (tick) begin
      unique case (state)
        IDLE: begin
          if (row_s != 4'd0) begin
            state_nx   = SCAN;
            col_idx_nx = 2'd0;
          end
        end
        SCAN: begin
          if (row_s == 4'd0) begin
            col_idx_nx = col_idx + 2'd1;
            if (col_idx == 2'd3) state_nx = IDLE;
          end else if (row_one_hot) begin
            row_r_nx   = row_s;
            deb_cnt_nx = 4'd1;
            state_nx   = CONFIRM;
          end else begin
            // Several rows at once means ghosting or a multi-key chord.
            state_nx = IDLE;
          end
        end
        CONFIRM: begin
          if (row_s == row_r) begin
            if (deb_cnt + 4'd1 == DEB_LAST) begin
              push       = 1'b1;
              deb_cnt_nx = '0;
              rel_cnt_nx = '0;
              state_nx   = HELD;
            end else begin
              deb_cnt_nx = deb_cnt + 4'd1;
            end
          end else begin
            deb_cnt_nx = '0;
            state_nx   = IDLE;
          end
        end
        HELD: begin
          if (row_s == 4'd0) begin
            if (rel_cnt + 4'd1 == DEB_LAST) begin
              rel_cnt_nx = '0;
              state_nx   = IDLE;
            end else begin
              rel_cnt_nx = rel_cnt + 4'd1;
            end
          end else begin
            rel_cnt_nx = '0;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // Column drive follows the registered state, so it lags a state change by one cycle.
  always_comb begin
    col_drive = 4'b0000;
    if (en) col_drive = (state == IDLE) ? 4'b1111 : (4'b0001 << col_idx);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      col_idx <= '0;
      row_r   <= '0;
      deb_cnt <= '0;
      rel_cnt <= '0;
      col     <= '0;
    end else begin
      state   <= state_nx;
      col_idx <= col_idx_nx;
      row_r   <= row_r_nx;
      deb_cnt <= deb_cnt_nx;
      rel_cnt <= rel_cnt_nx;
      col     <= col_drive;
    end
  end

  assign busy      = (state != IDLE);
  assign full      = (count == FIFO_FULL);
  assign key_valid = (count != '0);
  assign pop       = key_valid && key_ready;
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign push_ok   = push && (!full || pop);
  assign key_code  = key_valid ? mem[rd_ptr] : 4'd0;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= {row_idx, col_idx};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= push && full && !pop;
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: doc/keypad_scan_ctrl.md
Name: keypad_scan_ctrl

Overview:
- Timed scan controller for a 4x4 hex keypad.
- Paces column drive at a programmable dwell and synchronizes and debounces the row returns.
- Encodes each confirmed key press and queues the codes in a small FIFO.
- Sits between the raw keypad pins and the system consumer, which reads key codes over a valid/ready handshake.

Parameters:
- CLK_DIV, 1000: clk cycles per scan tick (column dwell); legal range 2..65535.
- DEBOUNCE, 4: consecutive identical tick samples needed to confirm a press or a release; legal range 2..15.
- FIFO_DEPTH, 4: key-code queue entries; power of two, 2..16.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- en  in  1  scan enable; low forces IDLE with col=0000
- row  in  4  raw keypad row returns, active-high, asynchronous to clk
- col  out  4  column drive, active-high, registered
- key_code  out  4  FIFO head code
- key_valid  out  1  FIFO non-empty
- key_ready  in  1  consumer accepts head when high with key_valid
- overflow  out  1  one-cycle pulse: confirmed key dropped, FIFO full
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values:
  - state=IDLE, col=0000, FIFO empty, key_valid=0, key_code=0000, overflow=0, busy=0.
  - All counters 0. Sync flops 0.
- Row synchronizer:
  - 2-flop synchronizer on row produces row_s.
  - All decisions use row_s, and only on tick cycles.
- Tick generator:
  - Counter runs 0..CLK_DIV-1 while en=1; tick=1 when the count equals CLK_DIV-1.
  - Counter clears when en=0.
- Code encoding:
  - Row bit i and column bit j give code = 4*i + j.
  - Example: row 0100 with col 0010 gives 4'h9.
- State machine (transitions on tick only, except the en override):
  - IDLE:
    - col=1111.
    - row_s!=0 → SCAN with col_idx=0.
  - SCAN:
    - col = one-hot(col_idx).
    - row_s one-hot → capture row_r=row_s, deb_cnt=1, go CONFIRM.
    - row_s=0 → col_idx+1; if col_idx was 3, go IDLE.
    - row_s has more than one bit set (ghost/multi-key) → IDLE.
  - CONFIRM:
    - col holds.
    - row_s==row_r → deb_cnt+1. When deb_cnt reaches DEBOUNCE, push the code in the same cycle and go HELD with rel_cnt=0.
    - row_s!=row_r → IDLE, no push.
  - HELD:
    - col holds.
    - row_s==0 → rel_cnt+1; reaching DEBOUNCE → IDLE.
    - row_s!=0 → rel_cnt=0.
    - No further push while the key stays down (no auto-repeat).
- en override:
  - en=0 → next cycle state=IDLE, col=0000, counters cleared.
  - FIFO contents are retained and stay readable.
- col timing: col is registered and updates the cycle after a state or col_idx change.
- FIFO:
  - Push occurs on the CONFIRM→HELD cycle; key_valid rises the next cycle if the FIFO was empty.
  - Pop occurs when key_valid && key_ready; the head advances the next cycle.
  - key_code stays stable while key_valid && !key_ready.
- FIFO boundaries:
  - Push when full and no pop that cycle → code dropped, overflow=1 for one cycle.
  - Push and pop in the same cycle when full → both succeed, no overflow.
  - Pop when empty → ignored.
  - Pointers wrap modulo FIFO_DEPTH.
- Reset mid-operation: asynchronous return to the reset values; in-flight debounce and all FIFO contents are discarded.

Test Plan:
- Single press, CLK_DIV=4, DEBOUNCE=2, key_ready=1:
  - Stimulus: row=0100 asserted only while col bit1 is driven, then held.
  - Response: col sequence 1111→0001→0010; one key_code=4'h9 with key_valid for 1 cycle; busy high until release is confirmed (2 ticks of row=0).
- Bounce rejection:
  - Stimulus: row toggles every tick during CONFIRM.
  - Response: no push, return to IDLE; a later stable press of row 0001 on col 1000 yields 4'h3.
- Ghost key:
  - Stimulus: row=0110 during SCAN.
  - Response: IDLE on the next tick, no push, no overflow.
- FIFO full with key_ready=0:
  - Stimulus: 5 distinct presses 0x0, 0x5, 0xA, 0xF, 0x6.
  - Response: exactly one overflow pulse on the 5th press; then draining with key_ready=1 yields 0,5,A,F in order.
- Backpressure and simultaneous push/pop:
  - Stimulus: FIFO full, then key_ready=1 in the same cycle as the 5th push.
  - Response: no overflow; the queue reads 5,A,F,6.
- en and reset mid-scan:
  - Stimulus: en=0 during HELD.
  - Response: col=0000 next cycle, queued codes still readable.
  - Stimulus: rst pulse mid-CONFIRM.
  - Response: key_valid=0, col=0000 immediately.
